// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: return-path owner encoding,
// data width and the default Wishbone window base.
package vga_fb_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_PIX  = 2'd1,
    OWNER_WB   = 2'd2
  } owner_e;

  localparam int          FB_DATA_W    = 32;
  localparam logic [31:0] FB_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads have priority, Wishbone gets the
// port after at most STARVE_LIMIT consecutive pixel grants while it waits.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = FB_BASE_ADDR,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [FB_DATA_W-1:0] wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [FB_DATA_W-1:0] wbs_dat_o,
  input  logic                 pix_req_i,
  input  logic [ADDR_W-1:0]    pix_addr_i,
  output logic                 pix_gnt_o,
  output logic                 pix_rvalid_o,
  output logic [FB_DATA_W-1:0] pix_rdata_o,
  output logic                 pix_stall_o,
  output logic                 ram_en_o,
  output logic [3:0]           ram_we_o,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic [FB_DATA_W-1:0] ram_wdata_o,
  input  logic [FB_DATA_W-1:0] ram_rdata_i
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  owner_e           owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stall_reg, stall_next;
  logic             wb_hit, starved, wb_gnt, pix_gnt;
  logic             unused_adr_lsb;

  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner_reg <= OWNER_NONE;
      cnt_reg   <= '0;
      stall_reg <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      stall_reg <= stall_next;
    end
  end

  // Grant decision and next state; grants are held off while reset is asserted
  always_comb begin
    wb_hit     = wbs_cyc_i && wbs_stb_i && (owner_reg != OWNER_WB) &&
                 (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    starved    = wb_hit && (cnt_reg == CNT_MAX);
    wb_gnt     = !wb_rst_i && wb_hit && (!pix_req_i || starved);
    pix_gnt    = !wb_rst_i && pix_req_i && !wb_gnt;
    stall_next = pix_req_i && !pix_gnt;

    owner_next = OWNER_NONE;
    if (wb_gnt) begin
      owner_next = OWNER_WB;
    end else if (pix_gnt) begin
      owner_next = OWNER_PIX;
    end

    cnt_next = cnt_reg;
    if (!wb_hit || wb_gnt) begin
      cnt_next = '0;
    end else if (pix_gnt && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Outputs: RAM port muxing and return-data steering by the registered owner
  always_comb begin
    pix_gnt_o    = pix_gnt;
    pix_stall_o  = stall_reg;
    ram_en_o     = wb_gnt || pix_gnt;
    ram_we_o     = 4'b0000;
    ram_addr_o   = pix_addr_i;
    ram_wdata_o  = '0;
    if (wb_gnt) begin
      ram_addr_o  = wbs_adr_i[ADDR_W+1:2];
      ram_we_o    = wbs_we_i ? wbs_sel_i : 4'b0000;
      ram_wdata_o = wbs_dat_i;
    end

    wbs_ack_o    = (owner_reg == OWNER_WB);
    wbs_dat_o    = wbs_ack_o ? ram_rdata_i : '0;
    pix_rvalid_o = (owner_reg == OWNER_PIX);
    pix_rdata_o  = pix_rvalid_o ? ram_rdata_i : '0;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM attached.
module tb_vga_fb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        pix_req_i;
  logic [9:0]  pix_addr_i;
  logic        pix_gnt_o, pix_rvalid_o, pix_stall_o;
  logic [31:0] pix_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o, ram_rdata_i;

  int checks = 0;
  int failures = 0;

  logic        mem_init;
  logic [31:0] mem [0:1023];

  always #5 wb_clk_i = ~wb_clk_i;

  vga_fb_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .pix_req_i(pix_req_i), .pix_addr_i(pix_addr_i), .pix_gnt_o(pix_gnt_o),
    .pix_rvalid_o(pix_rvalid_o), .pix_rdata_o(pix_rdata_o), .pix_stall_o(pix_stall_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Framebuffer model: word n initialised to 0xA500_0000 | n, registered read
  always @(posedge wb_clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (ram_en_o) begin
      if (ram_we_o == 4'b0000) ram_rdata_i <= mem[ram_addr_o];
      else for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  function automatic logic [31:0] exp_word(input int n);
    return (n == 2) ? 32'hA500_BEEF : (32'hA500_0000 | n);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_idle;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
  endtask

  task automatic wb_start(input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
  endtask

  int  ngrants;
  bit  done;

  initial begin
    wb_rst_i = 1'b1; mem_init = 1'b1; pix_req_i = 1'b0; pix_addr_i = '0;
    wb_idle();
    repeat (2) tick();
    mem_init = 1'b0;
    @(negedge wb_clk_i);
    check_eq("rst_ack", wbs_ack_o, 0);
    check_eq("rst_rvalid", pix_rvalid_o, 0);
    check_eq("rst_stall", pix_stall_o, 0);
    check_eq("rst_ram_en", ram_en_o, 0);
    tick(); wb_rst_i = 1'b0;

    // 1: idle WB read of word 4
    tick(); wb_start(1'b0, 4'hF, 32'h3000_0010, 0);
    @(negedge wb_clk_i);
    check_eq("t1_ram_en", ram_en_o, 1);
    check_eq("t1_ram_addr", ram_addr_o, 4);
    check_eq("t1_ram_we", ram_we_o, 0);
    check_eq("t1_ack_g", wbs_ack_o, 0);
    tick();
    @(negedge wb_clk_i);
    check_eq("t1_ack", wbs_ack_o, 1);
    check_eq("t1_dat", wbs_dat_o, 32'hA500_0004);
    tick(); wb_idle();
    @(negedge wb_clk_i);
    check_eq("t1_ack_once", wbs_ack_o, 0);
    check_eq("t1_dat_zero", wbs_dat_o, 0);

    // 2: partial write of word 2, then read back
    tick(); wb_start(1'b1, 4'b0011, 32'h3000_0008, 32'hDEAD_BEEF);
    @(negedge wb_clk_i);
    check_eq("t2_ram_we", ram_we_o, 4'b0011);
    check_eq("t2_ram_addr", ram_addr_o, 2);
    check_eq("t2_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    tick();
    @(negedge wb_clk_i);
    check_eq("t2_ack", wbs_ack_o, 1);
    tick(); wb_idle();
    tick(); wb_start(1'b0, 4'hF, 32'h3000_0008, 0);
    tick();
    @(negedge wb_clk_i);
    check_eq("t2_rb_ack", wbs_ack_o, 1);
    check_eq("t2_rb_dat", wbs_dat_o, 32'hA500_BEEF);
    tick(); wb_idle();

    // 3: starvation limit with pixel request held high
    tick(); pix_req_i = 1'b1; pix_addr_i = 10'h100;
    wb_start(1'b0, 4'hF, 32'h3000_000C, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk_i);
      check_eq($sformatf("t3_pgnt%0d", k), pix_gnt_o, 1);
      check_eq($sformatf("t3_paddr%0d", k), ram_addr_o, 10'h100 + k);
      check_eq($sformatf("t3_noack%0d", k), wbs_ack_o, 0);
      if (k > 0) check_eq($sformatf("t3_prd%0d", k), pix_rdata_o, exp_word(32'h100 + k - 1));
      tick(); pix_addr_i = 10'(10'h100 + k + 1);
    end
    @(negedge wb_clk_i);
    check_eq("t3_wb_pgnt", pix_gnt_o, 0);
    check_eq("t3_wb_addr", ram_addr_o, 3);
    check_eq("t3_wb_rdata", pix_rdata_o, exp_word(32'h107));
    tick();
    @(negedge wb_clk_i);
    check_eq("t3_ack", wbs_ack_o, 1);
    check_eq("t3_dat", wbs_dat_o, 32'hA500_0003);
    check_eq("t3_stall", pix_stall_o, 1);
    check_eq("t3_resume", pix_gnt_o, 1);
    check_eq("t3_rvalid0", pix_rvalid_o, 0);
    tick(); wb_idle(); pix_addr_i = 10'h109;
    @(negedge wb_clk_i);
    check_eq("t3_rvalid1", pix_rvalid_o, 1);
    check_eq("t3_rd108", pix_rdata_o, exp_word(32'h108));
    check_eq("t3_stall_clr", pix_stall_o, 0);
    tick(); pix_req_i = 1'b0;

    // 4: streaming pixel reads 0..15
    tick(); pix_req_i = 1'b1; pix_addr_i = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge wb_clk_i);
      check_eq($sformatf("t4_gnt%0d", n), pix_gnt_o, 1);
      check_eq($sformatf("t4_addr%0d", n), ram_addr_o, n);
      check_eq($sformatf("t4_stall%0d", n), pix_stall_o, 0);
      if (n > 0) begin
        check_eq($sformatf("t4_rv%0d", n), pix_rvalid_o, 1);
        check_eq($sformatf("t4_rd%0d", n), pix_rdata_o, exp_word(n - 1));
      end
      tick(); pix_addr_i = 10'(n + 1);
    end
    pix_req_i = 1'b0;
    @(negedge wb_clk_i);
    check_eq("t4_rv_last", pix_rvalid_o, 1);
    check_eq("t4_rd_last", pix_rdata_o, exp_word(15));
    check_eq("t4_stall_end", pix_stall_o, 0);

    // 5: out-of-window strobe is ignored
    tick(); wb_start(1'b0, 4'hF, 32'h3100_0000, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk_i);
      check_eq($sformatf("t5_en%0d", c), ram_en_o, 0);
      check_eq($sformatf("t5_ack%0d", c), wbs_ack_o, 0);
      tick();
    end
    wb_idle();

    // 6: reset during a read's ack cycle
    tick(); wb_start(1'b0, 4'hF, 32'h3000_0014, 0);
    @(negedge wb_clk_i);
    check_eq("t6_addr", ram_addr_o, 5);
    tick();
    @(negedge wb_clk_i);
    check_eq("t6_ack_pre", wbs_ack_o, 1);
    wb_rst_i = 1'b1; pix_req_i = 1'b1;
    @(negedge wb_clk_i);
    check_eq("t6_ack_rst", wbs_ack_o, 0);
    check_eq("t6_rv_rst", pix_rvalid_o, 0);
    check_eq("t6_stall_rst", pix_stall_o, 0);
    check_eq("t6_en_rst", ram_en_o, 0);
    @(negedge wb_clk_i);
    check_eq("t6_stall_rst2", pix_stall_o, 0);
    tick(); wb_rst_i = 1'b0;
    ngrants = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge wb_clk_i);
      if (pix_gnt_o) ngrants++;
      else if (ram_en_o) done = 1'b1;
      if (!done) tick();
    end
    check_eq("t6_wb_granted", done, 1);
    check_eq("t6_pix_before_wb", ngrants, 8);
    check_eq("t6_wb_addr", ram_addr_o, 5);
    tick();
    @(negedge wb_clk_i);
    check_eq("t6_ack", wbs_ack_o, 1);
    check_eq("t6_dat", wbs_dat_o, 32'hA500_0005);
    tick(); wb_idle(); pix_req_i = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
